// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one shared memory port,
// with address-range fault checks and a starvation bound for fetches.
module mem_port_arbiter #(
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 2,
    parameter logic [31:0] INST_BASE  = 32'h3000,
    parameter logic [31:0] MEM_TOP    = 32'h3FFC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic        i_err,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic        d_err,
    output logic [31:0] d_rdata,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic        m_read,
    output logic        m_write,
    input  logic [31:0] m_rdata,
    output logic        busy
);

    localparam int unsigned CW = 4;
    localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [SW-1:0]  starve_cnt;
    logic           side_i;
    logic           we_q;

    logic           starved_c;
    logic           grant_d_c;
    logic           grant_i_c;
    logic           win_we_c;
    logic           fault_c;
    logic [31:0]    win_addr_c;

    // Winner selection and fault classification for the request seen in IDLE
    always_comb begin
        starved_c  = (starve_cnt == SW'(STARVE_MAX));
        grant_d_c  = d_req && !(i_req && starved_c);
        grant_i_c  = i_req && !grant_d_c;
        win_addr_c = grant_d_c ? d_addr : i_addr;
        win_we_c   = grant_d_c && d_we;
        fault_c    = (win_addr_c[1:0] != 2'b00)
                  || (win_addr_c > MEM_TOP)
                  || (grant_i_c && (win_addr_c < INST_BASE))
                  || (win_we_c && (win_addr_c >= INST_BASE));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            starve_cnt <= '0;
            side_i     <= 1'b0;
            we_q       <= 1'b0;
            i_ack      <= 1'b0;
            i_err      <= 1'b0;
            i_rdata    <= '0;
            d_ack      <= 1'b0;
            d_err      <= 1'b0;
            d_rdata    <= '0;
            m_addr     <= '0;
            m_wdata    <= '0;
            m_read     <= 1'b0;
            m_write    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d_c || grant_i_c) begin
                        side_i <= grant_i_c;
                        busy   <= 1'b1;
                        if (grant_i_c) begin
                            starve_cnt <= '0;
                        end else if (i_req && !starved_c) begin
                            starve_cnt <= starve_cnt + SW'(1);
                        end
                        if (fault_c) begin
                            // Faults skip the memory entirely and answer next cycle
                            state <= RESP;
                            i_ack <= grant_i_c;
                            i_err <= grant_i_c;
                            d_ack <= grant_d_c;
                            d_err <= grant_d_c;
                            if (grant_i_c) begin
                                i_rdata <= '0;
                            end else begin
                                d_rdata <= '0;
                            end
                        end else begin
                            state   <= ACCESS;
                            m_addr  <= win_addr_c;
                            m_read  <= !win_we_c;
                            m_write <= win_we_c;
                            m_wdata <= win_we_c ? d_wdata : 32'h0;
                            we_q    <= win_we_c;
                            cnt     <= CW'(MEM_LAT);
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == CW'(1)) begin
                        state   <= RESP;
                        m_addr  <= '0;
                        m_wdata <= '0;
                        m_read  <= 1'b0;
                        m_write <= 1'b0;
                        if (side_i) begin
                            i_rdata <= m_rdata;
                            i_ack   <= 1'b1;
                        end else begin
                            d_rdata <= we_q ? 32'h0 : m_rdata;
                            d_ack   <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                    i_ack <= 1'b0;
                    i_err <= 1'b0;
                    d_ack <= 1'b0;
                    d_err <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1, memory access cycles per transaction (legal 1..15).
REQ-002 SHALL have parameter STARVE_MAX, default 2, consecutive data grants tolerated while i_req pending.
REQ-003 SHALL have parameter INST_BASE, default 32'h3000, first instruction-region byte address.
REQ-004 SHALL have parameter MEM_TOP, default 32'h3FFC, last legal word address.
REQ-005 SHALL use one clock and a synchronous active-high reset.
REQ-006 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-007 SHALL have port rst  in  1  synchronous active-high reset.
REQ-008 SHALL have port i_req  in  1  fetch request, held until i_ack.
REQ-009 SHALL have port i_addr  in  32  fetch byte address.
REQ-010 SHALL have ports i_ack  out  1, i_err  out  1 and i_rdata  out  32: fetch completion pulse, fault flag and instruction word.
REQ-011 SHALL have ports d_req  in  1, d_we  in  1, d_addr  in  32 and d_wdata  in  32: data request, write enable, byte address and store word.
REQ-012 SHALL have ports d_ack  out  1, d_err  out  1 and d_rdata  out  32: data completion pulse, fault flag and load word.
REQ-013 SHALL have ports m_addr  out  32, m_wdata  out  32, m_read  out  1 and m_write  out  1 driving the shared memory data port.
REQ-014 SHALL have port m_rdata  in  32, combinational read word from memory.
REQ-015 SHALL have port busy  out  1, high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE, with a fault path IDLE -> RESP.
REQ-017 SHALL arbitrate in IDLE only: if d_req and i_req are both high, data wins unless starve_cnt == STARVE_MAX, in which case fetch wins; a single request wins alone.
REQ-018 SHALL increment starve_cnt on each data grant made while i_req is high, saturating at STARVE_MAX, and clear it on any fetch grant.
REQ-019 SHALL latch the winner's address, d_we and d_wdata at the grant edge; requester fields are ignored until the matching ack.
REQ-020 SHALL flag a fault when addr[1:0] != 0 or addr > MEM_TOP; a fetch with addr < INST_BASE and a data write with addr >= INST_BASE SHALL also fault; data reads anywhere in 0..MEM_TOP SHALL be legal.
REQ-021 SHALL, on a fault, issue no m_read/m_write and go IDLE -> RESP, with err=1 and rdata=0 at ack.
REQ-022 SHALL, in ACCESS, hold m_addr stable and assert m_read (fetch or load) or m_write with m_wdata (store) for exactly MEM_LAT cycles, counted by a down-counter.
REQ-023 SHALL register m_rdata into the granted rdata output on the last ACCESS cycle; stores SHALL return rdata=0.
REQ-024 SHALL pulse only the granted side's ack for exactly one cycle in RESP, with rdata/err valid in that same cycle, then go to IDLE.
REQ-025 SHALL give a non-faulting request latency of MEM_LAT+2 cycles from req seen in IDLE to ack, and a faulting request latency of 2 cycles.
REQ-026 SHALL treat req still high in the cycle after ack as a new request.
REQ-027 SHALL drive m_addr, m_wdata, m_read and m_write to 0 outside ACCESS.
REQ-028 SHALL hold i_rdata/d_rdata until the next ack on the same side; err SHALL be valid only with ack.
REQ-029 SHALL never assert i_ack and d_ack in the same cycle.

Reset
REQ-030 SHALL, on rst high at a clock edge, enter IDLE, clear starve_cnt and the access counter, and zero all outputs, including mid-ACCESS or mid-RESP.
REQ-031 SHALL drop any in-flight transaction on reset without an ack, terminating m_write immediately.

Verification
REQ-032 SHALL cover: MEM_LAT=1, i_req at 0x3000 with mem word 0x8C010000 -> i_ack 3 cycles later, i_rdata=0x8C010000, i_err=0, m_read high 1 cycle.
REQ-033 SHALL cover: d_we=1, d_addr=0x0010, d_wdata=0xDEADBEEF -> m_write 1 cycle at m_addr 0x0010, d_ack, then a load from 0x0010 returns 0xDEADBEEF.
REQ-034 SHALL cover: d_req and i_req held high continuously with STARVE_MAX=2 -> grant order D,D,I,D,D,I; no ack overlap.
REQ-035 SHALL cover: d_we=1 at 0x3004 -> d_err=1 at 2 cycles, no m_write; i_addr 0x3002 -> i_err=1; d read at 0x4000 -> d_err=1.
REQ-036 SHALL cover: MEM_LAT=4, rst asserted on the 2nd ACCESS cycle of a store -> next cycle m_write=0, busy=0, no d_ack; a fresh request afterwards completes normally.
